// File: rtl/uart_rxtx_core.sv
// Full-duplex UART engine: oversampling-free receiver sampling at bit centres and a
// frame-shifting transmitter, both configured at runtime through static inputs.
//
// rx state | meaning
// IDLE     | line idle, watching for a falling edge
// START    | half-bit wait, then confirm start bit is still low
// DATA     | sampling data_bits bits, LSB first
// PARITY   | sampling the parity bit
// STOP     | sampling stop bit(s); on framing error waits for line high
module uart_rxtx_core (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] bit_rate,
   input  logic [3:0]  data_bits,
   input  logic [1:0]  stop_bits,
   input  logic        parity_bit,
   input  logic        parity_enabled,
   input  logic        parity_accept_errors,
   input  logic        rxd,
   output logic        rxd_syn,
   output logic [8:0]  rxd_data,
   input  logic        rxd_ack,
   output logic [2:0]  rxd_state,
   output logic        txd,
   input  logic        txd_syn,
   input  logic [7:0]  txd_data,
   output logic        txd_busy
);

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_t;

   // reset_n is active-high despite its name
   logic rst;
   assign rst = reset_n;

   logic        rxd_s1, rxd_s2, rxd_prev, rx_fall;
   rx_state_t   rx_state, rx_next;
   logic [15:0] rx_cnt;
   logic [3:0]  rx_idx;
   logic [8:0]  rx_shift;
   logic        rx_perr, rx_ferr;
   logic        rx_tick, rx_data_last, rx_stop_last, rx_deliver;

   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_s1   <= 1'b1;
         rxd_s2   <= 1'b1;
         rxd_prev <= 1'b1;
      end else begin
         rxd_s1   <= rxd;
         rxd_s2   <= rxd_s1;
         rxd_prev <= rxd_s2;
      end
   end

   assign rx_fall      = rxd_prev & ~rxd_s2;
   assign rx_tick      = (rx_cnt == 16'd0);
   assign rx_data_last = (rx_idx == (data_bits - 4'd1));
   assign rx_stop_last = (rx_idx == {3'b000, stop_bits[1]});

   always_ff @(posedge clk) begin
      if (rst) rx_state <= RX_IDLE;
      else     rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:   if (rx_fall) rx_next = RX_START;
         RX_START:  if (rx_tick) rx_next = rxd_s2 ? RX_IDLE : RX_DATA;
         RX_DATA:   if (rx_tick && rx_data_last) rx_next = parity_enabled ? RX_PARITY : RX_STOP;
         RX_PARITY: if (rx_tick) rx_next = RX_STOP;
         RX_STOP: begin
            if (rx_ferr) begin
               if (rxd_s2) rx_next = RX_IDLE;
            end else if (rx_tick && rxd_s2 && rx_stop_last) begin
               rx_next = RX_IDLE;
            end
         end
         default:   rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      rxd_state  = rx_state;
      rx_deliver = 1'b0;
      if (rx_state == RX_STOP && rx_tick && !rx_ferr && rxd_s2 && rx_stop_last)
         rx_deliver = !(rx_perr && !parity_accept_errors);
   end

   // Down-counter reloads with bit_rate-1 at every sample point, so samples land bit_rate apart
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_cnt   <= '0;
         rx_idx   <= '0;
         rx_shift <= '0;
         rx_perr  <= 1'b0;
         rx_ferr  <= 1'b0;
      end else if (rx_state == RX_IDLE) begin
         if (rx_fall) begin
            rx_cnt   <= (bit_rate >> 1) - 16'd1;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
         end
      end else if (rx_tick) begin
         rx_cnt <= bit_rate - 16'd1;
         case (rx_state)
            RX_DATA: begin
               rx_shift <= rx_shift | ({8'd0, rxd_s2} << rx_idx);
               rx_idx   <= rx_data_last ? 4'd0 : rx_idx + 4'd1;
            end
            RX_PARITY: rx_perr <= (^rx_shift) ^ rxd_s2 ^ parity_bit;
            RX_STOP: begin
               if (!rx_ferr) begin
                  if (!rxd_s2) rx_ferr <= 1'b1;
                  else         rx_idx  <= rx_idx + 4'd1;
               end
            end
            default: ;
         endcase
      end else begin
         rx_cnt <= rx_cnt - 16'd1;
      end
   end

   // A completion on the same edge as an ack keeps rxd_syn set
   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_syn  <= 1'b0;
         rxd_data <= '0;
      end else if (rx_deliver) begin
         rxd_syn  <= 1'b1;
         rxd_data <= rx_shift;
      end else if (rxd_ack) begin
         rxd_syn  <= 1'b0;
      end
   end

   logic [15:0] tx_frame, tx_shift, tx_cnt;
   logic [8:0]  tx_data9;
   logic [3:0]  tx_left, tx_len;
   logic        tx_par;

   assign tx_data9 = {1'b0, txd_data};
   assign tx_len   = 4'd1 + data_bits + {3'd0, parity_enabled} + (stop_bits[1] ? 4'd2 : 4'd1);

   // Whole frame is assembled at load time; idle and stop positions are ones
   always_comb begin
      tx_frame    = '1;
      tx_frame[0] = 1'b0;
      tx_par      = parity_bit;
      for (int i = 0; i < 9; i++) begin
         if (i < int'(data_bits)) begin
            tx_frame[i+1] = tx_data9[i];
            tx_par        = tx_par ^ tx_data9[i];
         end
      end
      if (parity_enabled) tx_frame[data_bits + 4'd1] = tx_par;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_shift <= '1;
         tx_cnt   <= '0;
         tx_left  <= '0;
         txd_busy <= 1'b0;
      end else if (!txd_busy) begin
         if (txd_syn) begin
            tx_shift <= tx_frame;
            tx_cnt   <= bit_rate - 16'd1;
            tx_left  <= tx_len - 4'd1;
            txd_busy <= 1'b1;
         end
      end else if (tx_cnt == 16'd0) begin
         tx_cnt   <= bit_rate - 16'd1;
         tx_shift <= {1'b1, tx_shift[15:1]};
         if (tx_left == 4'd0) txd_busy <= 1'b0;
         else                 tx_left  <= tx_left - 4'd1;
      end else begin
         tx_cnt <= tx_cnt - 16'd1;
      end
   end

   assign txd = tx_shift[0];

endmodule

// File: tb/tb_uart_rxtx_core.sv
// Self-checking bench for uart_rxtx_core: frames are built as bit lists from the
// UART framing rules and compared against the serial line and received words.
module tb_uart_rxtx_core;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] bit_rate;
   logic [3:0]  data_bits;
   logic [1:0]  stop_bits;
   logic        parity_bit, parity_enabled, parity_accept_errors;
   logic        rxd, rxd_drv, loop_en;
   logic        rxd_syn;
   logic [8:0]  rxd_data;
   logic        rxd_ack = 1'b0;
   logic [2:0]  rxd_state;
   logic        txd, txd_syn;
   logic [7:0]  txd_data;
   logic        txd_busy;

   always #5 clk = ~clk;

   assign rxd = loop_en ? txd : rxd_drv;

   uart_rxtx_core dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .bit_rate             (bit_rate),
      .data_bits            (data_bits),
      .stop_bits            (stop_bits),
      .parity_bit           (parity_bit),
      .parity_enabled       (parity_enabled),
      .parity_accept_errors (parity_accept_errors),
      .rxd                  (rxd),
      .rxd_syn              (rxd_syn),
      .rxd_data             (rxd_data),
      .rxd_ack              (rxd_ack),
      .rxd_state            (rxd_state),
      .txd                  (txd),
      .txd_syn              (txd_syn),
      .txd_data             (txd_data),
      .txd_busy             (txd_busy)
   );

   int checks = 0;
   int failures = 0;

   int         syn_cycles = 0, busy_cycles = 0, start_cycles = 0;
   logic       syn_prev = 1'b0, ack_d = 1'b0;
   logic [8:0] rx_words[$];
   bit         frame_q[$];

   // Host side: ack is rxd_syn delayed by one cycle; words logged on rxd_syn rise
   always @(negedge clk) begin
      rxd_ack = ack_d;
      ack_d   = (rxd_syn === 1'b1);
      if (rxd_syn === 1'b1) syn_cycles++;
      if (rxd_syn === 1'b1 && !syn_prev) rx_words.push_back(rxd_data);
      syn_prev = (rxd_syn === 1'b1);
      if (txd_busy === 1'b1) busy_cycles++;
      if (rxd_state === 3'd1) start_cycles++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int br, input int nb, input bit pe, input bit podd,
                          input int ns, input bit acc);
      bit_rate             = 16'(br);
      data_bits            = 4'(nb);
      parity_enabled       = pe;
      parity_bit           = podd;
      stop_bits            = (ns == 2) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
      parity_accept_errors = acc;
   endtask

   task automatic make_frame(input int data, input int nb, input bit pe, input bit podd,
                             input int ns, input bit bad_par, input bit bad_stop2);
      int par;
      frame_q.delete();
      frame_q.push_back(1'b0);
      par = podd;
      for (int i = 0; i < nb; i++) begin
         frame_q.push_back(bit'((data >> i) & 1));
         par = par ^ ((data >> i) & 1);
      end
      if (pe) frame_q.push_back(bit'(par ^ int'(bad_par)));
      frame_q.push_back(1'b1);
      if (ns == 2) frame_q.push_back(!bad_stop2);
   endtask

   task automatic drive_frame(input int br);
      foreach (frame_q[i]) begin
         rxd_drv = frame_q[i];
         tick(br);
      end
      rxd_drv = 1'b1;
      tick(2 * br + 6);
   endtask

   // Transmit one word and check every bit at its centre plus the busy duration
   task automatic tx_frame(input int data, input int br, input int nb, input bit pe,
                           input bit podd, input int ns, input bit interfere);
      int b0, nbits, w;
      set_cfg(br, nb, pe, podd, ns, 1'b0);
      make_frame(data, nb, pe, podd, ns, 1'b0, 1'b0);
      nbits = frame_q.size();
      b0 = busy_cycles;
      txd_data = 8'(data);
      txd_syn = 1'b1;
      tick(1);
      txd_syn = 1'b0;
      txd_data = 8'($urandom);
      checks++;
      if (txd_busy !== 1'b1) begin
         failures++;
         $display("FAIL tx_busy_rise: got %b expected 1", txd_busy);
      end
      for (int k = 0; k < nbits; k++) begin
         w = (k == 0) ? br / 2 : br;
         for (int c = 0; c < w; c++) begin
            tick(1);
            txd_syn = interfere && (k == 3) && (c == 0);
         end
         txd_syn = 1'b0;
         checks++;
         if (txd !== frame_q[k]) begin
            failures++;
            $display("FAIL tx_bit%0d data=%h: got %b expected %b", k, data, txd, frame_q[k]);
         end
      end
      tick(br - br / 2);
      checks++;
      if (txd_busy !== 1'b0 || busy_cycles - b0 != nbits * br) begin
         failures++;
         $display("FAIL tx_busy_len: got busy=%b cycles=%0d expected busy=0 cycles=%0d",
                  txd_busy, busy_cycles - b0, nbits * br);
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b1;
      loop_en = 1'b0;
      rxd_drv = 1'b1;
      txd_syn = 1'b0;
      txd_data = 8'h00;
      set_cfg(16, 8, 1'b0, 1'b0, 1, 1'b0);
      tick(3);
      checks++;
      if (txd !== 1'b1 || txd_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_tx: got txd=%b busy=%b expected txd=1 busy=0", txd, txd_busy);
      end
      checks++;
      if (rxd_syn !== 1'b0 || rxd_data !== 9'h000 || rxd_state !== 3'd0) begin
         failures++;
         $display("FAIL reset_rx: got syn=%b data=%h state=%0d expected 0 000 0",
                  rxd_syn, rxd_data, rxd_state);
      end
      reset_n = 1'b0;
      tick(3);
   endtask

   task automatic test_rx_8n1;
      int n0, s0;
      logic [8:0] got;
      set_cfg(16, 8, 1'b0, 1'b0, 1, 1'b0);
      make_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b0, 1'b0);
      n0 = rx_words.size();
      s0 = syn_cycles;
      drive_frame(16);
      got = (rx_words.size() > n0) ? rx_words[n0] : 9'hxxx;
      checks++;
      if (rx_words.size() != n0 + 1 || got !== 9'h0A5) begin
         failures++;
         $display("FAIL rx_8n1_data: got %h (words=%0d) expected 0a5 (words=1)", got, rx_words.size() - n0);
      end
      checks++;
      if (syn_cycles - s0 != 2) begin
         failures++;
         $display("FAIL rx_8n1_syn_len: got %0d expected 2", syn_cycles - s0);
      end
      checks++;
      if (rxd_state !== 3'd0) begin
         failures++;
         $display("FAIL rx_8n1_state: got %0d expected 0", rxd_state);
      end
   endtask

   task automatic test_rx_random;
      int br, nb, ns, data, n0, exp_cnt;
      bit pe, podd, acc, bp;
      logic [8:0] got;
      for (int it = 0; it < 10; it++) begin
         br   = $urandom_range(8, 24);
         nb   = $urandom_range(5, 9);
         pe   = 1'($urandom_range(0, 1));
         podd = 1'($urandom_range(0, 1));
         ns   = $urandom_range(1, 2);
         acc  = 1'($urandom_range(0, 1));
         bp   = pe ? 1'($urandom_range(0, 1)) : 1'b0;
         data = $urandom_range(0, (1 << nb) - 1);
         set_cfg(br, nb, pe, podd, ns, acc);
         make_frame(data, nb, pe, podd, ns, bp, 1'b0);
         n0 = rx_words.size();
         drive_frame(br);
         exp_cnt = (bp && !acc) ? 0 : 1;
         got = (rx_words.size() > n0) ? rx_words[n0] : 9'hxxx;
         checks++;
         if (rx_words.size() - n0 != exp_cnt || (exp_cnt == 1 && got !== 9'(data))) begin
            failures++;
            $display("FAIL rx_rand%0d br=%0d nb=%0d pe=%0d bad=%0d acc=%0d: got %h words=%0d expected %h words=%0d",
                     it, br, nb, pe, bp, acc, got, rx_words.size() - n0, 9'(data), exp_cnt);
         end
      end
   endtask

   task automatic test_parity;
      int n0;
      logic [8:0] got;
      set_cfg(16, 8, 1'b1, 1'b0, 1, 1'b0);
      make_frame(8'h03, 8, 1'b1, 1'b0, 1, 1'b1, 1'b0);
      n0 = rx_words.size();
      drive_frame(16);
      checks++;
      if (rx_words.size() != n0) begin
         failures++;
         $display("FAIL parity_drop: got %0d words expected 0", rx_words.size() - n0);
      end
      parity_accept_errors = 1'b1;
      n0 = rx_words.size();
      drive_frame(16);
      got = (rx_words.size() > n0) ? rx_words[n0] : 9'hxxx;
      checks++;
      if (rx_words.size() != n0 + 1 || got !== 9'h003) begin
         failures++;
         $display("FAIL parity_accept: got %h expected 003", got);
      end
   endtask

   task automatic test_9o2;
      int n0;
      logic [8:0] got;
      set_cfg(16, 9, 1'b1, 1'b1, 2, 1'b0);
      make_frame(9'h1FF, 9, 1'b1, 1'b1, 2, 1'b0, 1'b0);
      n0 = rx_words.size();
      drive_frame(16);
      got = (rx_words.size() > n0) ? rx_words[n0] : 9'hxxx;
      checks++;
      if (rx_words.size() != n0 + 1 || got !== 9'h1FF) begin
         failures++;
         $display("FAIL rx_9o2_data: got %h expected 1ff", got);
      end
      make_frame(9'h1FF, 9, 1'b1, 1'b1, 2, 1'b0, 1'b1);
      n0 = rx_words.size();
      drive_frame(16);
      checks++;
      if (rx_words.size() != n0 || rxd_state !== 3'd0) begin
         failures++;
         $display("FAIL rx_9o2_framing: got words=%0d state=%0d expected words=0 state=0",
                  rx_words.size() - n0, rxd_state);
      end
   endtask

   task automatic test_glitch;
      int n0, st0;
      set_cfg(16, 8, 1'b0, 1'b0, 1, 1'b0);
      n0 = rx_words.size();
      st0 = start_cycles;
      rxd_drv = 1'b0;
      tick(4);
      rxd_drv = 1'b1;
      tick(30);
      checks++;
      if (start_cycles == st0 || rxd_state !== 3'd0 || rx_words.size() != n0) begin
         failures++;
         $display("FAIL glitch: got start_cycles=%0d state=%0d words=%0d expected >0 0 0",
                  start_cycles - st0, rxd_state, rx_words.size() - n0);
      end
   endtask

   task automatic test_tx_loopback;
      int n0;
      logic [8:0] got;
      loop_en = 1'b1;
      n0 = rx_words.size();
      tx_frame(8'h3C, 10, 8, 1'b0, 1'b0, 1, 1'b1);
      tick(1);
      checks++;
      if (txd_busy !== 1'b0) begin
         failures++;
         $display("FAIL tx_ignore_busy: got busy=%b expected 0", txd_busy);
      end
      tick(20);
      got = (rx_words.size() > n0) ? rx_words[n0] : 9'hxxx;
      checks++;
      if (rx_words.size() != n0 + 1 || got !== 9'h03C) begin
         failures++;
         $display("FAIL tx_loopback: got %h words=%0d expected 03c words=1", got, rx_words.size() - n0);
      end
      loop_en = 1'b0;
   endtask

   task automatic test_back_to_back;
      int br, nb, ns, n0;
      bit pe, podd;
      int d[2];
      logic [8:0] g0, g1;
      loop_en = 1'b1;
      for (int it = 0; it < 3; it++) begin
         br   = $urandom_range(8, 20);
         nb   = $urandom_range(5, 9);
         pe   = 1'($urandom_range(0, 1));
         podd = 1'($urandom_range(0, 1));
         ns   = $urandom_range(1, 2);
         d[0] = $urandom_range(0, 255) & ((1 << nb) - 1);
         d[1] = $urandom_range(0, 255) & ((1 << nb) - 1);
         n0 = rx_words.size();
         tx_frame(d[0], br, nb, pe, podd, ns, 1'b0);
         tx_frame(d[1], br, nb, pe, podd, ns, 1'b0);
         tick(3 * br);
         g0 = (rx_words.size() > n0)     ? rx_words[n0]     : 9'hxxx;
         g1 = (rx_words.size() > n0 + 1) ? rx_words[n0 + 1] : 9'hxxx;
         checks++;
         if (rx_words.size() != n0 + 2 || g0 !== 9'(d[0]) || g1 !== 9'(d[1])) begin
            failures++;
            $display("FAIL b2b%0d br=%0d nb=%0d: got %h %h expected %h %h",
                     it, br, nb, g0, g1, 9'(d[0]), 9'(d[1]));
         end
      end
      loop_en = 1'b0;
   endtask

   task automatic test_reset_mid;
      set_cfg(16, 8, 1'b0, 1'b0, 1, 1'b0);
      txd_data = 8'h81;
      txd_syn = 1'b1;
      tick(1);
      txd_syn = 1'b0;
      rxd_drv = 1'b0;
      tick(40);
      checks++;
      if (rxd_state !== 3'd2 || txd_busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_frame: got state=%0d busy=%b expected 2 1", rxd_state, txd_busy);
      end
      reset_n = 1'b1;
      tick(1);
      checks++;
      if (txd !== 1'b1 || txd_busy !== 1'b0 || rxd_state !== 3'd0 || rxd_syn !== 1'b0 || rxd_data !== 9'h000) begin
         failures++;
         $display("FAIL reset_mid: got txd=%b busy=%b state=%0d syn=%b data=%h expected 1 0 0 0 000",
                  txd, txd_busy, rxd_state, rxd_syn, rxd_data);
      end
      rxd_drv = 1'b1;
      tick(2);
      reset_n = 1'b0;
      tick(5);
   endtask

   initial begin
      test_reset;
      test_rx_8n1;
      test_rx_random;
      test_parity;
      test_9o2;
      test_glitch;
      test_tx_loopback;
      test_back_to_back;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
